// File: rtl/booth_shift_ctrl.sv
// booth_shift_ctrl: radix-2 Booth multiplier sequencer.
// Owns the working register {A, Q, Q-1}, the latched multiplicand and the
// iteration counter; the add/subtract itself happens in an external
// accumulator that returns its result on acc_do one cycle after acc_en.
// Optional macro BOOTH_SKIP_EN: iterations whose Booth pair is 00 or 11 skip
// the accumulator and shift in place, so each one takes a single cycle.
module booth_shift_ctrl #(
   parameter int WIDTH_MUL = 5,
   parameter int WIDTH     = 2*WIDTH_MUL+1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [WIDTH_MUL-1:0]     multiplicand,
   input  logic [WIDTH_MUL-1:0]     multiplier,
   output logic [WIDTH-1:0]         acc_di,
   output logic [WIDTH_MUL-1:0]     acc_mul,
   output logic                     acc_en,
   output logic [1:0]               acc_s,
   input  logic [WIDTH-1:0]         acc_do,
   output logic                     busy,
   output logic                     done,
   output logic [2*WIDTH_MUL-1:0]   product
);

   localparam int CW = $clog2(WIDTH_MUL+1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_ADD   = 2'b01,
      S_SHIFT = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   state_t                   r_state;
   logic [WIDTH-1:0]         r_work;
   logic [WIDTH_MUL-1:0]     r_mul;
   logic [CW-1:0]            r_cnt;
   logic [2*WIDTH_MUL-1:0]   r_product;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_acc_en;

   state_t                   w_state_nxt;
   logic [WIDTH-1:0]         w_work_nxt;
   logic [WIDTH_MUL-1:0]     w_mul_nxt;
   logic [CW-1:0]            w_cnt_nxt;
   logic [2*WIDTH_MUL-1:0]   w_product_nxt;
   logic                     w_busy_nxt;
   logic                     w_done_nxt;
   logic                     w_acc_en_nxt;
   logic [WIDTH-1:0]         w_shift_acc;
   logic [WIDTH-1:0]         w_shift_self;
   logic                     w_last;

   // True when a Booth pair {Q0, Q-1} needs an add or subtract step.
   function automatic logic f_needs_op(input logic [1:0] pair);
      return pair[1] ^ pair[0];
   endfunction

   // Next-state, next-register and next-output computation.
   always_comb begin
      w_state_nxt   = r_state;
      w_work_nxt    = r_work;
      w_mul_nxt     = r_mul;
      w_cnt_nxt     = r_cnt;
      w_product_nxt = r_product;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_acc_en_nxt  = 1'b0;
      // Arithmetic right shift of the accumulator result / of the register itself.
      w_shift_acc   = $unsigned($signed(acc_do) >>> 1);
      w_shift_self  = $unsigned($signed(r_work) >>> 1);
      w_last        = (r_cnt == CW'(WIDTH_MUL-1));

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_work_nxt  = {{WIDTH_MUL{1'b0}}, multiplier, 1'b0};
               w_mul_nxt   = multiplicand;
               w_cnt_nxt   = {CW{1'b0}};
               w_busy_nxt  = 1'b1;
               w_state_nxt = S_ADD;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ADD: begin
`ifdef BOOTH_SKIP_EN
            if (!f_needs_op(r_work[1:0])) begin
               // No accumulator step needed: shift in place this cycle.
               w_work_nxt = w_shift_self;
               w_cnt_nxt  = r_cnt + CW'(1);
               if (w_last) begin
                  w_product_nxt = w_shift_self[WIDTH-1:1];
                  w_done_nxt    = 1'b1;
                  w_state_nxt   = S_DONE;
               end else begin
                  w_state_nxt   = S_ADD;
               end
            end else begin
               w_state_nxt = S_SHIFT;
            end
`else
            w_state_nxt = S_SHIFT;
`endif
         end
         S_SHIFT: begin
            w_work_nxt = w_shift_acc;
            w_cnt_nxt  = r_cnt + CW'(1);
            if (w_last) begin
               // Product is captured on entry to DONE so it is valid with done.
               w_product_nxt = w_shift_acc[WIDTH-1:1];
               w_done_nxt    = 1'b1;
               w_state_nxt   = S_DONE;
            end else begin
               w_state_nxt   = S_ADD;
            end
         end
         S_DONE: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_busy_nxt  = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase

      // acc_en is registered, so it is predicted from the state being entered.
      if (w_state_nxt == S_ADD) begin
`ifdef BOOTH_SKIP_EN
         w_acc_en_nxt = f_needs_op(w_work_nxt[1:0]);
`else
         w_acc_en_nxt = 1'b1;
`endif
      end else begin
         w_acc_en_nxt = 1'b0;
      end
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_work    <= {WIDTH{1'b0}};
         r_mul     <= {WIDTH_MUL{1'b0}};
         r_cnt     <= {CW{1'b0}};
         r_product <= {(2*WIDTH_MUL){1'b0}};
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_acc_en  <= 1'b0;
      end else begin
         r_work    <= w_work_nxt;
         r_mul     <= w_mul_nxt;
         r_cnt     <= w_cnt_nxt;
         r_product <= w_product_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_acc_en  <= w_acc_en_nxt;
      end
   end

   assign acc_di  = r_work;
   assign acc_mul = r_mul;
   assign acc_en  = r_acc_en;
   assign acc_s   = r_work[1:0];
   assign busy    = r_busy;
   assign done    = r_done;
   assign product = r_product;

endmodule

// File: tb/tb_booth_shift_ctrl.sv
// Testbench for booth_shift_ctrl: external accumulator model, cycle-level
// behavioural reference, directed literal cases and a randomized phase.
module tb_booth_shift_ctrl;

   localparam int N = 5;
   localparam int W = 2*N+1;
`ifdef BOOTH_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [N-1:0]   multiplicand = '0;
   logic [N-1:0]   multiplier = '0;
   logic [W-1:0]   acc_di;
   logic [N-1:0]   acc_mul;
   logic           acc_en;
   logic [1:0]     acc_s;
   logic [W-1:0]   acc_do;
   logic           busy;
   logic           done;
   logic [2*N-1:0] product;

   int checks = 0;
   int failures = 0;
   bit cmp_en = 1'b0;

   booth_shift_ctrl #(.WIDTH_MUL(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .acc_di(acc_di), .acc_mul(acc_mul), .acc_en(acc_en), .acc_s(acc_s),
      .acc_do(acc_do), .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   // External accumulator: adds/subtracts M into the A field when enabled.
   logic [W-1:0] acc_r = '0;
   always @(posedge clk) begin
      if (acc_en) begin
         case (acc_s)
            2'b01:   acc_r <= {acc_di[W-1:N+1] + acc_mul, acc_di[N:0]};
            2'b10:   acc_r <= {acc_di[W-1:N+1] - acc_mul, acc_di[N:0]};
            default: acc_r <= acc_di;
         endcase
      end
   end
   assign acc_do = acc_r;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference ----------------
   // m_cyc = cycles since the accepted start (0 = idle); m_len = done cycle.
   int             m_cyc = 0;
   int             m_len = 0;
   logic [2*N-1:0] m_prod = '0;
   logic [2*N-1:0] m_prod_pend = '0;
   logic [N-1:0]   m_mul = '0;
   bit             m_en [0:2*N+1];
   logic [1:0]     m_s  [0:2*N+1];

   // Build the per-cycle acc_en / acc_s schedule from the Booth pairs.
   task automatic plan(input logic [N-1:0] m, input logic [N-1:0] q);
      int c;
      int mi;
      int qi;
      int p;
      logic [N:0] qx;
      logic [1:0] pr;
      bit op;
      qx = {q, 1'b0};
      c = 1;
      for (int i = 0; i < N; i++) begin
         pr = qx[i +: 2];
         op = (pr == 2'b01) || (pr == 2'b10);
         if (!SKIP || op) begin
            m_en[c] = 1'b1; m_s[c] = pr;
            m_en[c+1] = 1'b0; m_s[c+1] = 2'b00;
            c += 2;
         end else begin
            m_en[c] = 1'b0; m_s[c] = 2'b00;
            c += 1;
         end
      end
      m_len = c;
      mi = $signed(m);
      qi = $signed(q);
      p = mi * qi;
      m_prod_pend = p[2*N-1:0];
      m_mul = m;
   endtask

   // Advance the reference once per clock.
   always @(posedge clk) begin
      if (rst) begin
         m_cyc = 0; m_prod = '0; m_mul = '0;
      end else if (m_cyc == 0) begin
         if (start) begin
            plan(multiplicand, multiplier);
            m_cyc = 1;
            if (m_cyc == m_len) m_prod = m_prod_pend;
         end
      end else if (m_cyc == m_len) begin
         m_cyc = 0;
      end else begin
         m_cyc++;
         if (m_cyc == m_len) m_prod = m_prod_pend;
      end
   end

   // Compare DUT against the reference every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic exp_en;
         exp_en = (m_cyc != 0 && m_cyc < m_len) ? m_en[m_cyc] : 1'b0;
         check("busy", 32'(busy), 32'(m_cyc != 0));
         check("done", 32'(done), 32'(m_cyc != 0 && m_cyc == m_len));
         check("acc_en", 32'(acc_en), 32'(exp_en));
         if (exp_en) check("acc_s", 32'(acc_s), 32'(m_s[m_cyc]));
         check("product", 32'(product), 32'(m_prod));
         check("acc_mul", 32'(acc_mul), 32'(m_mul));
      end
   end

   // ---------------- directed helpers ----------------
   task automatic run_op(input string name, input logic [N-1:0] m, input logic [N-1:0] q,
                         input logic [2*N-1:0] exp_prod, input int lat_plain, input int lat_skip,
                         input int en_plain, input int en_skip);
      int cyc;
      int nen;
      multiplicand = m; multiplier = q; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      nen = int'(acc_en);
      while (done !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
         nen += int'(acc_en);
      end
      check({name, "_latency"}, 32'(cyc), 32'(SKIP ? lat_skip : lat_plain));
      check({name, "_product"}, 32'(product), 32'(exp_prod));
      check({name, "_acc_en_count"}, 32'(nen), 32'(SKIP ? en_skip : en_plain));
      @(negedge clk);
      check({name, "_busy_after"}, 32'(busy), 32'd0);
      check({name, "_done_once"}, 32'(done), 32'd0);
   endtask

   initial begin
      int ndone;
      int nidle;
      int k;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      check("reset_product", 32'(product), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_acc_en", 32'(acc_en), 32'd0);
      check("reset_acc_di", 32'(acc_di), 32'd0);

      run_op("m5_q3",   5'd5,      5'd3,      10'h00F, 11, 8, 5, 2);
      run_op("mn7_q6",  5'b11001,  5'd6,      10'h3D6, 11, 8, 5, 2);
      run_op("m7_qn16", 5'd7,      5'b10000,  10'h390, 11, 7, 5, 1);

      // Start held high for 20 cycles: new operations only from IDLE after DONE.
      multiplicand = 5'd3; multiplier = 5'd3; start = 1'b1;
      ndone = 0; nidle = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (done) ndone++;
         if (!busy) nidle++;
      end
      start = 1'b0;
      check("held_start_done_count", 32'(ndone), SKIP ? 32'd2 : 32'd1);
      check("held_start_idle_count", 32'(nidle), SKIP ? 32'd2 : 32'd1);
      k = 0;
      while (busy && k < 40) begin
         @(negedge clk);
         k++;
      end
      check("held_start_finished", 32'(busy), 32'd0);
      check("held_start_product", 32'(product), 32'h009);

      // Reset in the middle of a 5*3 run.
      multiplicand = 5'd5; multiplier = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_product", 32'(product), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_acc_en", 32'(acc_en), 32'd0);
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("midrst_no_done", 32'(ndone), 32'd0);
      run_op("m2_qn1", 5'd2, 5'b11111, 10'h3FE, 11, 7, 5, 1);
      run_op("m0_q0",  5'd0, 5'd0,     10'h000, 11, 6, 5, 0);

      // Randomized phase: random starts (often while busy), operands, rare resets.
      for (int i = 0; i < 1500; i++) begin
         logic [N-1:0] rm;
         rm = N'($urandom);
         while (rm == 5'b10000) rm = N'($urandom);
         multiplicand = rm;
         multiplier = N'($urandom);
         start = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 199) == 0);
         @(negedge clk);
      end
      rst = 1'b0;
      start = 1'b0;
      repeat (30) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/booth_shift_ctrl.md
BOOTH_SHIFT_CTRL -- requirements
Module: booth_shift_ctrl

Interface
REQ-001 Parameter WIDTH_MUL, default 5: operand width N, two's complement.
REQ-002 Parameter WIDTH, default 2*WIDTH_MUL+1: working register width {A, Q, Q-1}.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 multiplicand  input  WIDTH_MUL  operand M, latched on accepted start.
REQ-007 multiplier  input  WIDTH_MUL  operand Q, latched on accepted start.
REQ-008 acc_di  output  WIDTH  working register, drives accumulator DI.
REQ-009 acc_mul  output  WIDTH_MUL  latched M, drives accumulator DI_MUL.
REQ-010 acc_en  output  1  accumulator enable.
REQ-011 acc_s  output  2  Booth select {Q0, Q-1} = acc_di[1:0].
REQ-012 acc_do  input  WIDTH  accumulator result, one cycle after acc_en.
REQ-013 busy  output  1  high from cycle after accepted start until done.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 product  output  2*WIDTH_MUL  signed M*Q, held until next accepted start.

Function
REQ-016 States: IDLE, ADD, SHIFT, DONE; one-hot or binary encoding is permitted.
REQ-017 IDLE with start=1: working register <= {0 (N bits), multiplier, 1'b0}, acc_mul <= multiplicand, iteration counter <= 0, busy <= 1, next ADD.
REQ-018 IDLE with start=0: all registers hold.
REQ-019 ADD: acc_en=1, acc_s=acc_di[1:0], working register held stable, next SHIFT.
REQ-020 SHIFT: acc_en=0; working register <= {acc_do[WIDTH-1], acc_do[WIDTH-1:1]} (arithmetic right shift by 1); counter increments.
REQ-021 SHIFT when counter reaches WIDTH_MUL-1 before increment: next DONE; otherwise next ADD.
REQ-022 DONE: product <= working register[WIDTH-1:1], done=1 for exactly one cycle, busy <= 0, next IDLE.
REQ-023 Without the feature in REQ-031, latency is fixed: done asserts 2*WIDTH_MUL+1 cycles after the cycle that sampled start (11 cycles at default).
REQ-024 acc_en is 0 in every state other than ADD.
REQ-025 acc_di stays constant through each ADD/SHIFT pair, because accumulator DO lower bits pass through combinationally from DI.
REQ-026 start while busy or in DONE is ignored; no queuing.
REQ-027 Both operands at full negative range are supported except multiplicand = -2^(WIDTH_MUL-1) with a subtract step; in that case product is undefined (accumulator negation overflow), and the block does not flag it.

Reset
REQ-028 rst=1 at any cycle, including mid-operation: state <= IDLE, working register, acc_mul, counter and product <= 0; busy=0, done=0, acc_en=0.
REQ-029 rst has priority over start in the same cycle.
REQ-030 The first start after rst deasserts is accepted normally.

Configuration
REQ-031 Macro BOOTH_SKIP_EN: when defined, ADD with acc_di[1:0] in {00, 11} does not pulse acc_en, shifts the working register in place ({r[WIDTH-1], r[WIDTH-1:1]}), increments the counter, and goes to ADD or DONE per REQ-021 (one cycle per iteration); when undefined, every iteration takes ADD+SHIFT (two cycles).
REQ-032 The product is identical with and without BOOTH_SKIP_EN; only latency and the acc_en pattern differ.

Verification
REQ-033 M=5, Q=3, start pulse -> product=10'h00F; done at cycle 11 (BOOTH_SKIP_EN undefined) or cycle 8 (defined).
REQ-034 M=-7, Q=6 -> product=10'h3D6 (-42); exactly one done pulse; busy low the cycle after done.
REQ-035 M=7, Q=-16 -> product=10'h390 (-112).
REQ-036 M=3, Q=3 with start held high for 20 cycles -> one product (10'h009); a second operation starts only in the IDLE cycle after DONE.
REQ-037 rst asserted at cycle 4 of a 5*3 run -> next cycle IDLE, product=0, busy=0, no done; then M=2, Q=-1 -> product=10'h3FE.
REQ-038 M=0, Q=0 -> product=0; with BOOTH_SKIP_EN defined, acc_en never asserts and done at cycle 6.
